// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle for serial_adder (optional sub under SERIAL_ADDER_SUB_EN)
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;

    // Producer/consumer side: drives operands and result acceptance
    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output in_valid, A, B, cin, out_ready,
        input  in_ready, out_valid, sum, carry
    );

    // Adder side: accepts operands and presents the result
    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  in_valid, A, B, cin, out_ready,
        output in_ready, out_valid, sum, carry
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial WIDTH-bit adder with registered carry chain (optional subtract under SERIAL_ADDER_SUB_EN)
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    // A zero DIGIT would otherwise break the STEPS division during elaboration.
    localparam int DIGIT_SAFE = (DIGIT < 1) ? 1 : DIGIT;
    localparam int STEPS      = WIDTH / DIGIT_SAFE;
    localparam int CNT_W      = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    if (WIDTH < 1) begin : g_bad_width
        $error("serial_adder: WIDTH must be >= 1 (got %0d)", WIDTH);
    end
    if (DIGIT < 1 || (WIDTH % DIGIT_SAFE) != 0) begin : g_bad_digit
        $error("serial_adder: DIGIT (%0d) must be >= 1 and divide WIDTH (%0d)", DIGIT, WIDTH);
    end
    if ($bits(bus.A) != WIDTH) begin : g_bad_bus
        $error("serial_adder: interface WIDTH does not match module WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    // Operand shifters: the low DIGIT bits are the digit being added this cycle.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Partial sum fills from the top so that after STEPS shifts it is aligned.
    logic [WIDTH-1:0] sum_sh;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    // Output registers; only updated on the RUN->DONE edge.
    logic [WIDTH-1:0] sum_q;
    logic             carry_out_q;

    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic [DIGIT:0]   digit_res;
    logic [WIDTH-1:0] sum_sh_nxt;

    // Operand conditioning at the accept edge; subtract is A + ~B + 1.
`ifdef SERIAL_ADDER_SUB_EN
    always_comb begin
        b_load = bus.sub ? ~bus.B : bus.B;
        c_load = bus.sub ? 1'b1 : bus.cin;
    end
`else
    always_comb begin
        b_load = bus.B;
        c_load = bus.cin;
    end
`endif

    // One digit of the ripple: low digits of both shifters plus the registered carry.
    always_comb begin
        digit_res  = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                   + (DIGIT+1)'(carry_q);
        sum_sh_nxt = (sum_sh >> DIGIT)
                   | (WIDTH'(digit_res[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; in_valid only matters in IDLE, out_ready only in DONE.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        last_step     = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_STEP) begin
                    last_step = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: capture at accept, shift one digit per RUN cycle, publish on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh        <= '0;
            b_sh        <= '0;
            sum_sh      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else if (accept) begin
            a_sh    <= bus.A;
            b_sh    <= b_load;
            carry_q <= c_load;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_sh    <= a_sh >> DIGIT;
            b_sh    <= b_sh >> DIGIT;
            sum_sh  <= sum_sh_nxt;
            carry_q <= digit_res[DIGIT];
            if (last_step) begin
                cnt_q       <= '0;
                sum_q       <= sum_sh_nxt;
                carry_out_q <= digit_res[DIGIT];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.sum   = sum_q;
    assign bus.carry = carry_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed bench for serial_adder at 8/1 and 16/4 (sub cases under SERIAL_ADDER_SUB_EN)
module tb_serial_adder;

    localparam int OV = 0;
    localparam int IR = 1;
    localparam int SM = 2;
    localparam int CY = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic sub_drv = 1'b0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  bus8 ();
    serial_adder_if #(.WIDTH(16)) bus16 ();

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] obs(input int sel, input int what);
        logic [31:0] r;
        r = '0;
        if (sel == 0) begin
            case (what)
                OV: r = 32'(bus8.out_valid);
                IR: r = 32'(bus8.in_ready);
                SM: r = 32'(bus8.sum);
                default: r = 32'(bus8.carry);
            endcase
        end else begin
            case (what)
                OV: r = 32'(bus16.out_valid);
                IR: r = 32'(bus16.in_ready);
                SM: r = 32'(bus16.sum);
                default: r = 32'(bus16.carry);
            endcase
        end
        return r;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic ordy);
        if (sel == 0) begin
            bus8.in_valid  = v;
            bus8.A         = a[7:0];
            bus8.B         = b[7:0];
            bus8.cin       = c;
            bus8.out_ready = ordy;
`ifdef SERIAL_ADDER_SUB_EN
            bus8.sub       = sub_drv;
`endif
        end else begin
            bus16.in_valid  = v;
            bus16.A         = a;
            bus16.B         = b;
            bus16.cin       = c;
            bus16.out_ready = ordy;
`ifdef SERIAL_ADDER_SUB_EN
            bus16.sub       = sub_drv;
`endif
        end
`ifndef SERIAL_ADDER_SUB_EN
        if (sub_drv) $display("note: sub ignored in this build");
`endif
    endtask

    // One full operation with out_ready held high; operands are scrambled right after accept.
    task automatic run_op(input int sel, input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [15:0] esum, input logic ecarry);
        int n;
        int low;
        int steps;
        steps = (sel == 0) ? 8 : 4;
        drive(sel, 1'b1, a, b, c, 1'b1);
        @(negedge clk);
        drive(sel, 1'b0, ~a, ~b, ~c, 1'b1);
        n   = 0;
        low = 0;
        while (obs(sel, OV) == 0 && n < 100) begin
            if (obs(sel, IR) == 0) low++;
            @(negedge clk);
            n++;
        end
        check({tag, "/latency"}, n, steps);
        check({tag, "/sum"}, obs(sel, SM), 32'(esum));
        check({tag, "/carry"}, obs(sel, CY), 32'(ecarry));
        if (obs(sel, IR) == 0) low++;
        @(negedge clk);
        check({tag, "/idle_out_valid"}, obs(sel, OV), 0);
        check({tag, "/idle_in_ready"}, obs(sel, IR), 1);
        check({tag, "/sum_held"}, obs(sel, SM), 32'(esum));
        check({tag, "/busy_cycles"}, low, steps + 1);
    endtask

    initial begin
        int n;
        int bad;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] rref;

        rst_n = 1'b0;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst8/out_valid", obs(0, OV), 0);
        check("rst8/in_ready", obs(0, IR), 1);
        check("rst8/sum", obs(0, SM), 0);
        check("rst8/carry", obs(0, CY), 0);
        check("rst16/in_ready", obs(1, IR), 1);
        check("rst16/sum", obs(1, SM), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, "w8_zero", 16'h00, 16'h00, 1'b0, 16'h00, 1'b0);
        run_op(0, "w8_ff_01", 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1);
        run_op(0, "w8_7f_80_c", 16'h7F, 16'h80, 1'b1, 16'h00, 1'b1);
        run_op(0, "w8_12_34", 16'h12, 16'h34, 1'b0, 16'h46, 1'b0);
        run_op(0, "w8_a5_5a_c", 16'hA5, 16'h5A, 1'b1, 16'h00, 1'b1);
        run_op(0, "w8_c3_0f", 16'hC3, 16'h0F, 1'b0, 16'hD2, 1'b0);

        run_op(1, "w16_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op(1, "w16_1234_4321_c", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
        run_op(1, "w16_8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom_range(0, 1));
            rref = {1'b0, ra} + {1'b0, rb} + 17'(rc);
            run_op(1, "w16_rand", ra, rb, rc, rref[15:0], rref[16]);
        end

        // Backpressure: result must hold while out_ready is low and new operands wait.
        drive(0, 1'b1, 16'h80, 16'h80, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 16'h00, 16'h00, 1'b0, 1'b0);
        n = 0;
        while (obs(0, OV) == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp/latency", n, 8);
        check("bp/sum", obs(0, SM), 32'h01);
        check("bp/carry", obs(0, CY), 1);
        drive(0, 1'b1, 16'h01, 16'h02, 1'b0, 1'b0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (obs(0, OV) != 1 || obs(0, SM) != 32'h01 || obs(0, CY) != 1 || obs(0, IR) != 0) bad++;
        end
        check("bp/stable_cycles_bad", bad, 0);
        drive(0, 1'b1, 16'h01, 16'h02, 1'b0, 1'b1);
        @(negedge clk);
        check("bp/release_out_valid", obs(0, OV), 0);
        check("bp/release_in_ready", obs(0, IR), 1);
        @(negedge clk);
        check("bp/next_accepted", obs(0, IR), 0);
        drive(0, 1'b0, 16'hFF, 16'hFF, 1'b1, 1'b1);
        n = 0;
        while (obs(0, OV) == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp/next_latency", n, 8);
        check("bp/next_sum", obs(0, SM), 32'h03);
        check("bp/next_carry", obs(0, CY), 0);
        @(negedge clk);

        // Reset during RUN: everything returns to reset values at once, no result follows.
        drive(0, 1'b1, 16'hFF, 16'hFF, 1'b1, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 16'h00, 16'h00, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst/out_valid", obs(0, OV), 0);
        check("midrst/in_ready", obs(0, IR), 1);
        check("midrst/sum", obs(0, SM), 0);
        check("midrst/carry", obs(0, CY), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (obs(0, OV) != 0 || obs(0, IR) != 1) bad++;
        end
        check("midrst/no_result", bad, 0);
        run_op(0, "post_rst", 16'h3C, 16'h0F, 1'b0, 16'h4B, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        sub_drv = 1'b1;
        run_op(0, "sub_05_07", 16'h05, 16'h07, 1'b0, 16'hFE, 1'b0);
        run_op(0, "sub_07_05", 16'h07, 16'h05, 1'b0, 16'h02, 1'b1);
        run_op(0, "sub_07_05_cin", 16'h07, 16'h05, 1'b1, 16'h02, 1'b1);
        run_op(1, "sub16_eq", 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1);
        sub_drv = 1'b0;
        run_op(0, "sub0_add", 16'h05, 16'h07, 1'b1, 16'h0D, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
